// File: rtl/fft_pkg.sv
// Shared definitions for the 1024-point q1.15 FFT: sizes, loader states, and the
// bit-reversed index helpers that map a natural-order sample onto the two working banks.
package fft_pkg;

    localparam int N        = 1024;
    localparam int LOG2N    = 10;
    localparam int DW       = 16;
    localparam int ADDR_W   = LOG2N - 1;
    localparam int BSRAM_AW = 11;

    typedef logic [LOG2N-1:0] index_t;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_DRAIN = 2'd1,
        S_KICK  = 2'd2,
        S_WAIT  = 2'd3
    } loader_state_t;

    function automatic index_t bitrev(input index_t v);
        index_t r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

    // The top index bit picks the bank; the remaining bits are the word address inside it.
    function automatic logic bank_sel(input index_t v);
        return v[LOG2N-1];
    endfunction

    function automatic logic [ADDR_W-1:0] bank_addr(input index_t v);
        return v[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/fft_input_loader_if.sv
// Valid/ready sample stream feeding the FFT input loader.
interface fft_input_loader_if
    import fft_pkg::*;
#(
    parameter int WIDTH = DW
) ();

    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_re;
    logic [WIDTH-1:0] s_im;
    logic             s_last;

    modport master (
        output s_valid,
        output s_re,
        output s_im,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_re,
        input  s_im,
        input  s_last,
        output s_ready
    );

endinterface

// File: rtl/fft_input_loader.sv
// Loads a natural-order frame into the FFT banks in bit-reversed order, then hands
// the banks to the FFT core for one run and takes them back when it finishes.
module fft_input_loader
    import fft_pkg::*;
#(
    parameter int IN_SHIFT = 0
) (
    input  logic                clk,
    input  logic                rst,
    fft_input_loader_if.slave   bus,
    output logic                ce0,
    output logic                oce0,
    output logic                wre0,
    output logic [BSRAM_AW-1:0] ad0,
    output logic [2*DW-1:0]     din0,
    output logic                ce1,
    output logic                oce1,
    output logic                wre1,
    output logic [BSRAM_AW-1:0] ad1,
    output logic [2*DW-1:0]     din1,
    output logic                fft_start,
    input  logic                fft_finish,
    output logic                bank_owner,
    output logic                frame_done,
    output logic                err_len
);

    loader_state_t state_q, state_d;
    index_t        cnt_q, cnt_d;

    logic                ready_q, ready_d;
    logic                ce_q, ce_d;
    logic                wre0_d, wre1_d;
    logic [BSRAM_AW-1:0] ad0_d, ad1_d;
    logic [2*DW-1:0]     din0_d, din1_d;
    logic                start_d, owner_d, done_d, err_d;

    logic                accept;
    logic                last_slot;
    index_t              rev;
    logic [BSRAM_AW-1:0] rev_addr;
    logic signed [DW-1:0] re_sh, im_sh;
    logic [2*DW-1:0]     sample_word;

    assign accept      = bus.s_valid && ready_q && (state_q == S_LOAD);
    assign last_slot   = (cnt_q == index_t'(N - 1));
    assign rev         = bitrev(cnt_q);
    assign rev_addr    = {{(BSRAM_AW - ADDR_W){1'b0}}, bank_addr(rev)};
    assign re_sh       = $signed(bus.s_re) >>> IN_SHIFT;
    assign im_sh       = $signed(bus.s_im) >>> IN_SHIFT;
    assign sample_word = {re_sh, im_sh};

    assign bus.s_ready = ready_q;
    assign ce0         = ce_q;
    assign ce1         = ce_q;
    assign oce0        = 1'b0;
    assign oce1        = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LOAD;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            ce_q       <= 1'b0;
            wre0       <= 1'b0;
            wre1       <= 1'b0;
            ad0        <= '0;
            ad1        <= '0;
            din0       <= '0;
            din1       <= '0;
            fft_start  <= 1'b0;
            bank_owner <= 1'b0;
            frame_done <= 1'b0;
            err_len    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            ce_q       <= ce_d;
            wre0       <= wre0_d;
            wre1       <= wre1_d;
            ad0        <= ad0_d;
            ad1        <= ad1_d;
            din0       <= din0_d;
            din1       <= din1_d;
            fft_start  <= start_d;
            bank_owner <= owner_d;
            frame_done <= done_d;
            err_len    <= err_d;
        end
    end

    // Everything is computed one cycle ahead so every output leaves a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wre0_d  = 1'b0;
        wre1_d  = 1'b0;
        ad0_d   = '0;
        ad1_d   = '0;
        din0_d  = '0;
        din1_d  = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    if (bank_sel(rev)) begin
                        wre1_d = 1'b1;
                        ad1_d  = rev_addr;
                        din1_d = sample_word;
                    end else begin
                        wre0_d = 1'b1;
                        ad0_d  = rev_addr;
                        din0_d = sample_word;
                    end

                    if (bus.s_last && !last_slot) begin
                        err_d = 1'b1;
                        cnt_d = '0;
                    end else if (last_slot) begin
                        err_d   = !bus.s_last;
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: state_d = S_KICK;
            S_KICK:  state_d = S_WAIT;
            S_WAIT: begin
                // A finish level seen during S_KICK is stale; only S_WAIT looks at it.
                if (fft_finish) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase

        ready_d = (state_q == S_LOAD) && (state_d == S_LOAD);
        ce_d    = (state_q == S_LOAD);
        start_d = (state_d == S_KICK);
        owner_d = (state_d == S_KICK) || (state_d == S_WAIT);
    end

endmodule

// File: tb/tb_fft_input_loader.sv
// Self-checking bench for fft_input_loader: a frame-level model predicts every output each
// cycle, a stub FFT answers start with finish, and directed frames exercise the edge cases.
module tb_fft_input_loader;
    import fft_pkg::*;

    logic clk;
    logic rst;

    fft_input_loader_if #(.WIDTH(DW)) bus ();
    fft_input_loader_if #(.WIDTH(DW)) bus2 ();

    logic                ce0, oce0, wre0, ce1, oce1, wre1;
    logic [BSRAM_AW-1:0] ad0, ad1;
    logic [2*DW-1:0]     din0, din1;
    logic                fft_start, fft_finish, bank_owner, frame_done, err_len;

    logic                ce0_b, oce0_b, wre0_b, ce1_b, oce1_b, wre1_b;
    logic [BSRAM_AW-1:0] ad0_b, ad1_b;
    logic [2*DW-1:0]     din0_b, din1_b;
    logic                start_b, owner_b, done_b, err_b;
    logic                finish_b;

    fft_input_loader #(.IN_SHIFT(0)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .ce0(ce0), .oce0(oce0), .wre0(wre0), .ad0(ad0), .din0(din0),
        .ce1(ce1), .oce1(oce1), .wre1(wre1), .ad1(ad1), .din1(din1),
        .fft_start(fft_start), .fft_finish(fft_finish), .bank_owner(bank_owner),
        .frame_done(frame_done), .err_len(err_len)
    );

    fft_input_loader #(.IN_SHIFT(1)) dut_shift (
        .clk(clk), .rst(rst), .bus(bus2.slave),
        .ce0(ce0_b), .oce0(oce0_b), .wre0(wre0_b), .ad0(ad0_b), .din0(din0_b),
        .ce1(ce1_b), .oce1(oce1_b), .wre1(wre1_b), .ad1(ad1_b), .din1(din1_b),
        .fft_start(start_b), .fft_finish(finish_b), .bank_owner(owner_b),
        .frame_done(done_b), .err_len(err_b)
    );

    assign finish_b = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int passed = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            passed++;
    endtask

    // Stub FFT: clears finish when it samples start, raises it 100 cycles later and holds it.
    int stub_timer;
    always @(posedge clk) begin
        if (rst) begin
            fft_finish <= 1'b0;
            stub_timer <= 0;
        end else if (fft_start) begin
            fft_finish <= 1'b0;
            stub_timer <= 99;
        end else if (stub_timer > 0) begin
            stub_timer <= stub_timer - 1;
            if (stub_timer == 1)
                fft_finish <= 1'b1;
        end
    end

    function automatic int revIndex(input int n);
        int r = 0;
        int v = n;
        for (int i = 0; i < LOG2N; i++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    // Frame-level model: how many samples this frame holds, and how many edges since it filled.
    int          cyc = 0;
    bit          m_loading, m_ready, m_ce, m_owner, m_start, m_done, m_err;
    bit          m_wr0, m_wr1;
    int          m_cnt, m_full_age;
    logic [10:0] m_ad0, m_ad1;
    logic [31:0] m_din0, m_din1;
    logic [31:0] model_mem [N];
    logic [31:0] cap_mem [N];
    logic [31:0] snap_mem [N];

    always @(posedge clk) begin : model
        int r;
        bit was_loading;
        logic [31:0] word;
        cyc++;
        was_loading = m_loading;
        m_wr0 = 0; m_wr1 = 0; m_ad0 = '0; m_ad1 = '0; m_din0 = '0; m_din1 = '0;
        m_start = 0; m_done = 0; m_err = 0;
        if (rst) begin
            m_loading = 1; m_cnt = 0; m_ready = 0; m_owner = 0; m_full_age = 0; m_ce = 0;
        end else begin
            m_ce = was_loading;
            if (m_loading) begin
                if (bus.s_valid && m_ready) begin
                    r    = revIndex(m_cnt);
                    word = {bus.s_re, bus.s_im};
                    model_mem[r] = word;
                    if (r >= N / 2) begin
                        m_wr1 = 1; m_ad1 = 11'(r - N / 2); m_din1 = word;
                    end else begin
                        m_wr0 = 1; m_ad0 = 11'(r); m_din0 = word;
                    end
                    if (bus.s_last && m_cnt != N - 1) begin
                        m_err = 1; m_cnt = 0;
                    end else if (m_cnt == N - 1) begin
                        m_err = !bus.s_last; m_loading = 0; m_full_age = 0;
                    end else begin
                        m_cnt++;
                    end
                end
                m_ready = m_loading;
            end else begin
                m_ready = 0;
                if (m_full_age == 0) begin
                    m_start = 1; m_owner = 1;
                end else if (m_full_age >= 2 && fft_finish) begin
                    m_done = 1; m_owner = 0; m_loading = 1; m_cnt = 0;
                end
                m_full_age++;
            end
        end
    end

    bit checking = 0;
    int start_count = 0, done_count = 0, err_count = 0;
    int start_cyc = 0, done_cyc = 0, last_acc_cyc = 0;

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("s_ready", bus.s_ready, m_ready);
            checkOutput("ce0", ce0, m_ce);
            checkOutput("ce1", ce1, m_ce);
            checkOutput("oce", {oce0, oce1}, 2'b00);
            checkOutput("wre0", wre0, m_wr0);
            checkOutput("wre1", wre1, m_wr1);
            checkOutput("ad0", ad0, m_ad0);
            checkOutput("ad1", ad1, m_ad1);
            checkOutput("din0", din0, m_din0);
            checkOutput("din1", din1, m_din1);
            checkOutput("fft_start", fft_start, m_start);
            checkOutput("bank_owner", bank_owner, m_owner);
            checkOutput("frame_done", frame_done, m_done);
            checkOutput("err_len", err_len, m_err);
            if (wre0 === 1'b1) cap_mem[ad0[8:0]] = din0;
            if (wre1 === 1'b1) cap_mem[512 + int'(ad1[8:0])] = din1;
            if (fft_start === 1'b1) begin start_count++; start_cyc = cyc; end
            if (frame_done === 1'b1) begin done_count++; done_cyc = cyc; end
            if (err_len === 1'b1) err_count++;
        end
    end

    task automatic applyStimulus(input bit valid, input logic [15:0] re, input logic [15:0] im,
                                 input bit last, output bit accepted);
        @(negedge clk);
        bus.s_valid = valid;
        bus.s_re    = re;
        bus.s_im    = im;
        bus.s_last  = last;
        accepted    = valid && (bus.s_ready === 1'b1);
    endtask

    task automatic runFrame(input int count, input int last_pos, input int base, input bit throttle);
        int idx = 0;
        int guard = 0;
        bit acc;
        bit idle_phase = 0;
        while (idx < count && guard < 6000) begin
            if (throttle && idle_phase) begin
                applyStimulus(0, 16'h0, 16'h0, 0, acc);
            end else begin
                applyStimulus(1, 16'(base + idx), 16'h0, (idx == last_pos), acc);
                if (acc) begin
                    if (idx == count - 1) last_acc_cyc = cyc;
                    idx++;
                end
            end
            idle_phase = !idle_phase;
            guard++;
        end
        applyStimulus(0, 16'h0, 16'h0, 0, acc);
        checkOutput("frame_accepts", idx, count);
    endtask

    task automatic waitDone();
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (frame_done !== 1'b1 && g < 3000);
        checkOutput("done_seen", frame_done, 1'b1);
        checkOutput("ready_at_done", bus.s_ready, 1'b0);
        @(negedge clk);
        checkOutput("ready_after_done", bus.s_ready, 1'b1);
    endtask

    task automatic rstPulse(input string name);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput({name, "_outputs_zero"},
                    {wre0, wre1, ce0, ce1, oce0, oce1, fft_start, bank_owner, frame_done,
                     err_len, bus.s_ready, |ad0, |ad1, |din0, |din1}, 64'h0);
        @(negedge clk);
        checkOutput({name, "_ready"}, bus.s_ready, 1'b1);
    endtask

    task automatic compareMem(input string name, input bit against_snap);
        int bad = 0;
        for (int i = 0; i < N; i++) begin
            if (against_snap ? (cap_mem[i] !== snap_mem[i]) : (cap_mem[i] !== model_mem[i]))
                bad++;
        end
        checkOutput(name, bad, 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin : main
        int g;
        int s0, e0;
        rst = 1'b1;
        bus.s_valid = 0; bus.s_re = '0; bus.s_im = '0; bus.s_last = 0;
        bus2.s_valid = 0; bus2.s_re = '0; bus2.s_im = '0; bus2.s_last = 0;
        for (int i = 0; i < N; i++) begin
            model_mem[i] = '0; cap_mem[i] = '0; snap_mem[i] = '0;
        end

        repeat (2) @(negedge clk);
        rst = 1'b0;
        checking = 1;
        checkOutput("reset_outputs_zero",
                    {wre0, wre1, ce0, ce1, fft_start, bank_owner, frame_done, err_len,
                     bus.s_ready, |ad0, |ad1, |din0, |din1}, 64'h0);
        @(negedge clk);
        checkOutput("reset_ready", bus.s_ready, 1'b1);

        $display("[TB] IN_SHIFT=1 sign extension");
        g = 0;
        while (bus2.s_ready !== 1'b1 && g < 20) begin @(negedge clk); g++; end
        bus2.s_valid = 1; bus2.s_re = 16'h8000; bus2.s_im = 16'h7FFF;
        @(negedge clk);
        bus2.s_valid = 0;
        checkOutput("shift_din0", din0_b, 32'hC000_3FFF);
        checkOutput("shift_wre0", wre0_b, 1'b1);

        $display("[TB] ramp frame, valid held high");
        runFrame(N, N - 1, 0, 0);
        waitDone();
        checkOutput("start_latency", start_cyc - last_acc_cyc, 2);
        checkOutput("finish_to_done", done_cyc - start_cyc, 101);
        checkOutput("n1_fft1_ad0", cap_mem[512], 32'h0001_0000);
        checkOutput("n2_fft0_ad256", cap_mem[256], 32'h0002_0000);
        checkOutput("n3_fft1_ad256", cap_mem[768], 32'h0003_0000);
        checkOutput("n1023_fft1_ad511", cap_mem[1023], 32'h03FF_0000);
        compareMem("ramp_mem", 0);
        for (int i = 0; i < N; i++) snap_mem[i] = cap_mem[i];
        for (int i = 0; i < N; i++) cap_mem[i] = '0;

        $display("[TB] ramp frame, valid toggling");
        runFrame(N, N - 1, 0, 1);
        waitDone();
        compareMem("throttled_mem", 1);

        $display("[TB] early s_last at sample 500");
        s0 = start_count; e0 = err_count;
        runFrame(501, 500, 0, 0);
        repeat (8) @(negedge clk);
        checkOutput("early_last_err", err_count - e0, 1);
        checkOutput("early_last_nostart", start_count - s0, 0);
        runFrame(N, N - 1, 100, 0);
        waitDone();
        checkOutput("clean_after_err_start", start_count - s0, 1);
        checkOutput("clean_after_err_noerr", err_count - e0, 1);
        checkOutput("clean_after_err_idx0", cap_mem[0], 32'h0064_0000);

        $display("[TB] full frame without s_last");
        s0 = start_count; e0 = err_count;
        runFrame(N, -1, 3, 0);
        waitDone();
        checkOutput("nolast_err", err_count - e0, 1);
        checkOutput("nolast_start", start_count - s0, 1);

        $display("[TB] reset during FFT wait");
        runFrame(N, N - 1, 7, 0);
        g = 0;
        while (bank_owner !== 1'b1 && g < 100) begin @(negedge clk); g++; end
        checkOutput("owner_seen", bank_owner, 1'b1);
        repeat (10) @(negedge clk);
        rstPulse("rst_wait");

        $display("[TB] reset mid-load at cnt=300");
        runFrame(300, -1, 0, 0);
        rstPulse("rst_load");
        runFrame(N, N - 1, 5, 0);
        waitDone();
        checkOutput("after_rst_idx0", cap_mem[0], 32'h0005_0000);
        compareMem("after_rst_mem", 0);

        repeat (4) @(negedge clk);
        checking = 0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fft_input_loader.md
Name: fft_input_loader

Overview:
Upstream stage of the 1024-point fixed-point FFT core (q1.15). Accepts a stream of complex samples in natural order and writes them into the two FFT working BSRAMs in bit-reversed order. Bank fft0 holds reversed indices 0..511 and bank fft1 holds 512..1023, both at address index[8:0]. After a full frame it pulses the FFT start, holds bank ownership for the FFT until finish, then releases the banks for the next frame.

Parameters:
N, 1024, frame length in points; power of two.
LOG2N, 10, log2(N).
DW, 16, width of each re/im component (q1.15).
IN_SHIFT, 0, arithmetic right shift applied to re/im on entry to give butterfly headroom (0..3).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
s_valid  in  1  input sample valid
s_ready  out  1  loader can accept a sample this cycle
s_re  in  DW  sample real part, q1.15
s_im  in  DW  sample imaginary part, q1.15
s_last  in  1  marks the final sample of a frame
ce0, oce0, wre0  out  1 each  fft0 BSRAM enables
ad0  out  11  fft0 address; bit 10 is always 0
din0  out  32  fft0 write data {re, im}
ce1, oce1, wre1  out  1 each  fft1 BSRAM enables
ad1  out  11  fft1 address
din1  out  32  fft1 write data {re, im}
fft_start  out  1  one-cycle start pulse to the FFT core
fft_finish  in  1  FFT core finish flag; level, cleared by the core on start
bank_owner  out  1  0 = loader drives the banks, 1 = FFT drives them (top-level mux select)
frame_done  out  1  one-cycle pulse when the FFT result is in the banks
err_len  out  1  one-cycle pulse on a frame-length error

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port rst.
- Reset values: all outputs are 0, state is S_LOAD, the sample counter is 0, and s_ready becomes 1 on the first cycle after reset.
- S_LOAD:
  - s_ready = 1; ce0 = ce1 = 1; oce = 0.
  - A sample is accepted when s_valid && s_ready.
  - r = bitrev(cnt, LOG2N).
  - Next cycle (1-cycle write latency, registered): wre[r[9]] = 1, ad = {1'b0, r[8:0]}, din = {s_re>>>IN_SHIFT, s_im>>>IN_SHIFT}. The other bank's wre = 0.
  - No accept means both wre = 0 next cycle. cnt increments on each accept.
- Length checks:
  - s_last accepted with cnt != N-1: pulse err_len, discard the frame, cnt returns to 0, stay in S_LOAD. The write already issued is not undone.
  - Accept at cnt == N-1 with s_last = 0: pulse err_len, proceed anyway.
  - Accept at cnt == N-1 (either case): go to S_DRAIN, s_ready = 0.
- S_DRAIN (1 cycle): the last write completes. Then wre = 0, ce = 0, bank_owner = 1, go to S_KICK.
- S_KICK (1 cycle): fft_start = 1, go to S_WAIT.
- S_WAIT: s_ready = 0, bank_owner = 1, all bank outputs 0.
  - The FFT clears finish on the same edge it samples start, so finish is already 0 on the first S_WAIT cycle.
  - On fft_finish == 1: frame_done = 1 for one cycle, bank_owner = 0, cnt = 0, go to S_LOAD.
  - fft_finish == 1 in S_KICK (stale level from the previous run) is ignored.
- Reset mid-frame or mid-FFT: return to S_LOAD. The partial frame is lost and bank_owner drops to 0 immediately. The FFT core must be reset by the same reset.
- Timing: s_valid held high loads a frame in exactly N cycles. The first s_ready after frame_done comes one cycle after the pulse.
- IN_SHIFT is an arithmetic shift with sign extension and no rounding.

Decomposition:
- Shared package fft_pkg: N, LOG2N, DW, the bitrev function, and the bank-select/address split (bit LOG2N-1 selects the bank; the low bits are the address). The FFT core uses the same package.
- No sub-module; the state machine, counter and write register stay in one module.

Test Plan:
- Ramp frame, s_re = n, s_im = 0, s_valid held high:
  - n=1 -> fft1 ad 0 data 0x0001_0000.
  - n=2 -> fft0 ad 256.
  - n=3 -> fft1 ad 256.
  - n=1023 -> fft1 ad 511.
  - fft_start pulses exactly 2 cycles after the 1024th accept.
- Throttled input, s_valid toggling 1/0: no write in any idle cycle (wre0 = wre1 = 0), and the final bank contents equal those of the unthrottled run.
- s_last at sample 500: err_len pulses, no fft_start, cnt = 0. A following clean 1024-sample frame starts the FFT normally.
- Stub FFT raises fft_finish 100 cycles after start: bank_owner = 1 and s_ready = 0 throughout, then frame_done pulses once and s_ready = 1 on the next cycle.
- IN_SHIFT = 1, s_re = 0x8000, s_im = 0x7FFF -> din = 0xC000_3FFF.
- rst asserted in S_WAIT and in mid-load at cnt = 300: all outputs read 0 on the next cycle, then s_ready = 1, and the next frame loads from index 0.
